game_round_controller: RTL and testbench

Parametrised round and lives controller for the maze game. It replaces the fixed four-ghost, reset-on-death game logic with a counted-lives state machine over N ghosts. It gates sprite movement with a programmable move tick, detects tile-level pacman/ghost collisions, and sequences READY, PLAY, DYING and GAME_OVER. It sits between the per-sprite position update units (which consume move_tick and respawn) and the video/score front end (which consumes state, lives and game_over).

---
 rtl/game_pkg.sv | 35 +++
 rtl/tile_collision_array.sv | 56 +++++
 rtl/game_round_controller.sv | 140 ++++++++++++++
 tb/tb_game_round_controller.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
`default_nettype none
// ============================================================================
// Module   : game_pkg
// Purpose  : Shared types and constants for the maze game round logic:
//            FSM state encodings, sprite direction codes, default ratios.
// Revision : 1.0 - initial release
// ============================================================================
package game_pkg;

  // Encoded round state, also exported on the controller's state port
  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_READY     = 3'd1,
    ST_PLAY      = 3'd2,
    ST_DYING     = 3'd3,
    ST_GAME_OVER = 3'd4
  } state_t;

  // One-hot sprite direction codes used by the position update units
  localparam logic [3:0] c_DIR_RIGHT = 4'b0001;
  localparam logic [3:0] c_DIR_UP    = 4'b0010;
  localparam logic [3:0] c_DIR_DOWN  = 4'b0100;
  localparam logic [3:0] c_DIR_LEFT  = 4'b1000;

  // Default clk cycles per movement step and default tile size (log2 pixels)
  localparam int c_DEF_RATIO      = 4;
  localparam int c_DEF_TILE_SHIFT = 4;

  // Width of an index into n channels; never narrower than one bit
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/tile_collision_array.sv
`default_nettype none
// ============================================================================
// Module   : tile_collision_array
// Purpose  : Combinational tile-level pacman/ghost overlap detector with a
//            lowest-index priority encoder over the enabled ghosts.
// Revision : 1.0 - initial release
// ============================================================================
module tile_collision_array
  import game_pkg::*;
#(
  parameter int N_GHOSTS   = 4,
  parameter int X_W        = 11,
  parameter int Y_W        = 10,
  parameter int TILE_SHIFT = c_DEF_TILE_SHIFT
) (
  input  logic [X_W-1:0]                   pacman_pos_x,
  input  logic [Y_W-1:0]                   pacman_pos_y,
  input  logic [N_GHOSTS*X_W-1:0]          ghost_pos_x,
  input  logic [N_GHOSTS*Y_W-1:0]          ghost_pos_y,
  input  logic [N_GHOSTS-1:0]              ghost_en,
  output logic                             hit_any,
  output logic [idx_width(N_GHOSTS)-1:0]   hit_idx
);

  localparam int c_IDX_W = idx_width(N_GHOSTS);

  logic [X_W-1:0]      w_pac_tx;
  logic [Y_W-1:0]      w_pac_ty;
  logic [N_GHOSTS-1:0] w_hit;

  assign w_pac_tx = pacman_pos_x >> TILE_SHIFT;
  assign w_pac_ty = pacman_pos_y >> TILE_SHIFT;

  // Per-ghost tile comparison; a disabled ghost can never report a hit
  for (genvar gi = 0; gi < N_GHOSTS; gi++) begin : g_ghost
    logic [X_W-1:0] w_gx;
    logic [Y_W-1:0] w_gy;
    assign w_gx       = ghost_pos_x[gi*X_W +: X_W];
    assign w_gy       = ghost_pos_y[gi*Y_W +: Y_W];
    assign w_hit[gi]  = ghost_en[gi]
                        && ((w_gx >> TILE_SHIFT) == w_pac_tx)
                        && ((w_gy >> TILE_SHIFT) == w_pac_ty);
  end

  assign hit_any = |w_hit;

  // Scan from the top down so the lowest hitting index is the last writer
  always_comb begin
    hit_idx = '0;
    for (int i = N_GHOSTS - 1; i >= 0; i--) begin
      if (w_hit[i]) hit_idx = i[c_IDX_W-1:0];
    end
  end

endmodule
`default_nettype wire

// File: rtl/game_round_controller.sv
`default_nettype none
// ============================================================================
// Module   : game_round_controller
// Purpose  : Round and lives sequencer (IDLE/READY/PLAY/DYING/GAME_OVER)
//            with a programmable movement tick and tile collision detection
//            over N ghosts.
// Revision : 1.0 - initial release
// ============================================================================
module game_round_controller
  import game_pkg::*;
#(
  parameter int N_GHOSTS    = 4,
  parameter int X_W         = 11,
  parameter int Y_W         = 10,
  parameter int TILE_SHIFT  = c_DEF_TILE_SHIFT,
  parameter int TICK_PERIOD = c_DEF_RATIO,
  parameter int LIVES       = 3,
  parameter int READY_HOLD  = 32,
  parameter int DEATH_HOLD  = 64
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             start,
  input  logic [X_W-1:0]                   pacman_pos_x,
  input  logic [Y_W-1:0]                   pacman_pos_y,
  input  logic [N_GHOSTS*X_W-1:0]          ghost_pos_x,
  input  logic [N_GHOSTS*Y_W-1:0]          ghost_pos_y,
  input  logic [N_GHOSTS-1:0]              ghost_en,
  output logic                             move_tick,
  output logic                             respawn,
  output logic                             pacman_is_dead,
  output logic [idx_width(N_GHOSTS)-1:0]   killer_id,
  output logic [3:0]                       lives_left,
  output logic                             game_over,
  output logic [2:0]                       state
);

  localparam int c_IDX_W    = idx_width(N_GHOSTS);
  localparam int c_HOLD_MAX = (READY_HOLD > DEATH_HOLD) ? READY_HOLD : DEATH_HOLD;
  localparam int c_HOLD_W   = $clog2(c_HOLD_MAX + 1);
  localparam int c_TICK_W   = $clog2(TICK_PERIOD);

  localparam logic [c_HOLD_W-1:0] c_READY_LAST = c_HOLD_W'(READY_HOLD - 1);
  localparam logic [c_HOLD_W-1:0] c_DEATH_LAST = c_HOLD_W'(DEATH_HOLD - 1);
  localparam logic [c_TICK_W-1:0] c_TICK_LAST  = c_TICK_W'(TICK_PERIOD - 1);
  localparam logic [3:0]          c_LIVES_INIT = 4'(LIVES);

  state_t               r_state;
  state_t               w_state_next;
  logic [c_HOLD_W-1:0]  r_hold_cnt;
  logic [c_TICK_W-1:0]  r_tick_cnt;
  logic [3:0]           r_lives;
  logic [c_IDX_W-1:0]   r_killer;
  logic                 r_respawn;
  logic                 w_tick;
  logic                 w_hit_any;
  logic [c_IDX_W-1:0]   w_hit_idx;

  tile_collision_array #(
    .N_GHOSTS   (N_GHOSTS),
    .X_W        (X_W),
    .Y_W        (Y_W),
    .TILE_SHIFT (TILE_SHIFT)
  ) u_collide (
    .pacman_pos_x (pacman_pos_x),
    .pacman_pos_y (pacman_pos_y),
    .ghost_pos_x  (ghost_pos_x),
    .ghost_pos_y  (ghost_pos_y),
    .ghost_en     (ghost_en),
    .hit_any      (w_hit_any),
    .hit_idx      (w_hit_idx)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_next;
  end

  // Next-state decode and movement tick; a hit leaves this cycle's tick intact
  always_comb begin
    w_state_next = r_state;
    w_tick       = 1'b0;
    case (r_state)
      ST_IDLE:      if (start) w_state_next = ST_READY;
      ST_READY:     if (r_hold_cnt == c_READY_LAST) w_state_next = ST_PLAY;
      ST_PLAY: begin
        w_tick = (r_tick_cnt == c_TICK_LAST);
        if (w_hit_any) w_state_next = ST_DYING;
      end
      ST_DYING:
        if (r_hold_cnt == c_DEATH_LAST)
          w_state_next = (r_lives == 4'd0) ? ST_GAME_OVER : ST_READY;
      ST_GAME_OVER: if (start) w_state_next = ST_READY;
      default:      w_state_next = ST_IDLE;
    endcase
  end

  // Hold/tick counters, lives, killer and the one-cycle respawn pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      r_hold_cnt <= '0;
      r_tick_cnt <= '0;
      r_lives    <= c_LIVES_INIT;
      r_killer   <= '0;
      r_respawn  <= 1'b0;
    end else begin
      r_respawn <= (w_state_next == ST_READY) && (r_state != ST_READY);

      if (w_state_next != r_state)
        r_hold_cnt <= '0;
      else if (r_state == ST_READY || r_state == ST_DYING)
        r_hold_cnt <= r_hold_cnt + 1'b1;

      if (r_state == ST_PLAY && w_state_next == ST_PLAY)
        r_tick_cnt <= w_tick ? '0 : r_tick_cnt + 1'b1;
      else
        r_tick_cnt <= '0;

      // Lives are always >=1 in PLAY, so this decrement cannot wrap
      if (r_state == ST_PLAY && w_hit_any) begin
        r_lives  <= r_lives - 1'b1;
        r_killer <= w_hit_idx;
      end else if (r_state == ST_GAME_OVER && start) begin
        r_lives  <= c_LIVES_INIT;
        r_killer <= '0;
      end
    end
  end

  assign move_tick      = w_tick;
  assign respawn        = r_respawn;
  assign pacman_is_dead = (r_state == ST_DYING);
  assign killer_id      = r_killer;
  assign lives_left     = r_lives;
  assign game_over      = (r_state == ST_GAME_OVER);
  assign state          = r_state;

endmodule
`default_nettype wire

// File: tb/tb_game_round_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_game_round_controller
// Purpose  : Self-checking bench for game_round_controller: phase/elapsed
//            reference model compared every cycle, plus directed scenarios.
// Revision : 1.0 - initial release
// ============================================================================
module tb_game_round_controller;

  localparam int NG    = 4;
  localparam int TICK  = 4;
  localparam int NLIV  = 3;
  localparam int RHOLD = 32;
  localparam int DHOLD = 64;
  localparam int TILE  = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  int          px, py;
  int          gx[NG];
  int          gy[NG];
  logic [3:0]  ge;

  logic [10:0] pacman_pos_x;
  logic [9:0]  pacman_pos_y;
  logic [43:0] ghost_pos_x;
  logic [39:0] ghost_pos_y;
  logic        move_tick, respawn, pacman_is_dead, game_over;
  logic [1:0]  killer_id;
  logic [3:0]  lives_left;
  logic [2:0]  state;

  assign pacman_pos_x = 11'(px);
  assign pacman_pos_y = 10'(py);
  assign ghost_pos_x  = {11'(gx[3]), 11'(gx[2]), 11'(gx[1]), 11'(gx[0])};
  assign ghost_pos_y  = {10'(gy[3]), 10'(gy[2]), 10'(gy[1]), 10'(gy[0])};

  game_round_controller #(
    .N_GHOSTS(NG), .X_W(11), .Y_W(10), .TILE_SHIFT(4), .TICK_PERIOD(TICK),
    .LIVES(NLIV), .READY_HOLD(RHOLD), .DEATH_HOLD(DHOLD)
  ) dut (
    .clk(clk), .rst(rst), .start(start),
    .pacman_pos_x(pacman_pos_x), .pacman_pos_y(pacman_pos_y),
    .ghost_pos_x(ghost_pos_x), .ghost_pos_y(ghost_pos_y), .ghost_en(ge),
    .move_tick(move_tick), .respawn(respawn), .pacman_is_dead(pacman_is_dead),
    .killer_id(killer_id), .lives_left(lives_left), .game_over(game_over),
    .state(state)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  bit cmp_en   = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: phase number, cycles spent in it, lives, killer, respawn
  int m_ph, m_el, m_lives, m_killer;
  bit m_resp;

  function automatic int first_hit();
    for (int i = 0; i < NG; i++)
      if (ge[i] && (gx[i] / TILE == px / TILE) && (gy[i] / TILE == py / TILE))
        return i;
    return -1;
  endfunction

  always @(posedge clk) begin : model
    int nph, nl, nk, k;
    if (rst) begin
      m_ph <= 0; m_el <= 0; m_lives <= NLIV; m_killer <= 0; m_resp <= 1'b0;
    end else begin
      nph = m_ph; nl = m_lives; nk = m_killer;
      k = first_hit();
      if (m_ph == 0 && start)                 nph = 1;
      else if (m_ph == 1 && m_el == RHOLD-1)  nph = 2;
      else if (m_ph == 2 && k >= 0) begin     nph = 3; nl = m_lives - 1; nk = k; end
      else if (m_ph == 3 && m_el == DHOLD-1)  nph = (m_lives == 0) ? 4 : 1;
      else if (m_ph == 4 && start) begin      nph = 1; nl = NLIV; nk = 0; end
      m_resp   <= (nph == 1) && (m_ph != 1);
      m_el     <= (nph == m_ph) ? m_el + 1 : 0;
      m_ph     <= nph;
      m_lives  <= nl;
      m_killer <= nk;
    end
  end

  // Every-cycle comparison against the model
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("state", state, m_ph);
      chk("move_tick", move_tick, (m_ph == 2) && ((m_el % TICK) == TICK-1));
      chk("respawn", respawn, m_resp);
      chk("pacman_is_dead", pacman_is_dead, m_ph == 3);
      chk("game_over", game_over, m_ph == 4);
      chk("lives_left", lives_left, m_lives);
      chk("killer_id", killer_id, m_killer);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_state(input int s, input int budget);
    int n = 0;
    while (int'(state) != s && n < budget) begin step(); n++; end
    if (int'(state) != s) begin
      n_checks++; n_errors++;
      $display("FAIL wait_state: state %0d required %0d within %0d cycles", state, s, budget);
    end
  endtask

  task automatic ghosts_home();
    for (int i = 0; i < NG; i++) begin gx[i] = 500 + 40*i; gy[i] = 400; end
    ge = 4'b1111;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1);
  end

  initial begin
    int resp, rdy, ticks, first, pidx;
    rst = 1'b1; start = 1'b0; px = 100; py = 50;
    ghosts_home();
    step(); cmp_en = 1'b1; step(); step();
    chk("rst_state", state, 0);
    chk("rst_lives", lives_left, 3);
    chk("rst_killer", killer_id, 0);
    chk("rst_respawn", respawn, 0);
    rst = 1'b0; step();

    // Start: one respawn, 32 READY cycles, ticks on the 4th PLAY cycle and every 4th after
    start = 1'b1; step(); start = 1'b0;
    resp = 0; rdy = 0; ticks = 0; first = -1; pidx = 0;
    for (int i = 0; i < 40; i++) begin
      if (respawn) resp++;
      if (state == 3'd1) rdy++;
      if (state == 3'd2) begin
        if (move_tick) begin ticks++; if (first < 0) first = pidx; end
        pidx++;
      end
      step();
    end
    chk("respawn_pulses", resp, 1);
    chk("ready_cycles", rdy, 32);
    chk("first_tick_play_idx", first, 3);
    chk("ticks_in_8_play", ticks, 2);

    // Ghost2 on pacman's tile: (111,63) vs (100,50) -> tile (6,3)
    gx[2] = 111; gy[2] = 63; step();
    chk("hit1_state", state, 3);
    chk("hit1_dead", pacman_is_dead, 1);
    chk("hit1_lives", lives_left, 2);
    chk("hit1_killer", killer_id, 2);
    ticks = 0;
    for (int i = 0; i < 63; i++) begin
      if (i == 10) ghosts_home();
      if (move_tick) ticks++;
      step();
    end
    chk("dying_ticks", ticks, 0);

    // Disabled ghost0 on the tile: no death, ticks keep coming
    wait_state(2, 200);
    ge = 4'b1110; gx[0] = 104; gy[0] = 55; ticks = 0;
    for (int i = 0; i < 12; i++) begin step(); if (move_tick) ticks++; end
    chk("disabled_ticks", ticks, 3);
    chk("disabled_state", state, 2);
    // Ghosts 1 and 3 hit together -> lowest index wins
    gx[1] = 96; gy[1] = 48; gx[3] = 109; gy[3] = 61; step();
    chk("tie_killer", killer_id, 1);
    chk("tie_lives", lives_left, 1);
    ghosts_home();

    // Hit in a tick cycle: that tick stands, nothing after it
    wait_state(2, 200);
    step(); step(); step();
    chk("tick_on_hit_cycle", move_tick, 1);
    gx[3] = 100; gy[3] = 50; step();
    chk("hit3_state", state, 3);
    chk("hit3_killer", killer_id, 3);
    chk("hit3_lives", lives_left, 0);
    chk("hit3_no_tick", move_tick, 0);
    ghosts_home();
    start = 1'b1; step(); start = 1'b0;
    resp = 0;
    for (int i = 0; i < 70; i++) begin if (respawn) resp++; step(); end
    chk("gameover_respawns", resp, 0);
    chk("gameover_state", state, 4);
    chk("gameover_flag", game_over, 1);
    chk("gameover_lives", lives_left, 0);
    chk("gameover_killer_frozen", killer_id, 3);

    // Restart from GAME_OVER
    start = 1'b1; step(); start = 1'b0;
    chk("restart_state", state, 1);
    chk("restart_respawn", respawn, 1);
    chk("restart_lives", lives_left, 3);
    chk("restart_killer", killer_id, 0);
    start = 1'b1; step(); start = 1'b0;
    chk("ready_start_no_respawn", respawn, 0);

    // Reset mid-DYING
    wait_state(2, 100);
    start = 1'b1; step(); start = 1'b0;
    gx[2] = 111; gy[2] = 63; step();
    chk("hit4_state", state, 3);
    ghosts_home();
    for (int i = 0; i < 5; i++) step();
    rst = 1'b1; step(); rst = 1'b0;
    chk("rstdie_state", state, 0);
    chk("rstdie_lives", lives_left, 3);
    chk("rstdie_killer", killer_id, 0);
    chk("rstdie_outs", {move_tick, respawn, pacman_is_dead, game_over}, 0);

    // Reset mid-PLAY
    start = 1'b1; step(); start = 1'b0;
    wait_state(2, 100);
    for (int i = 0; i < 5; i++) step();
    rst = 1'b1; step(); rst = 1'b0;
    chk("rstplay_state", state, 0);
    chk("rstplay_lives", lives_left, 3);
    chk("rstplay_outs", {move_tick, respawn, pacman_is_dead, game_over}, 0);
    for (int i = 0; i < 4; i++) step();

    cmp_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
